// File: rtl/sig_pkg.sv
// Shared Q8.24 constants, segment boundaries, expansion points and FSM state
// encoding for the piecewise-Taylor sigmoid sequencer.
package sig_pkg;

    localparam int SEG_W = 3;

    localparam logic [31:0] ONE  = 32'h0100_0000;
    localparam logic [31:0] HALF = 32'h0080_0000;

    localparam logic [31:0] TH_1 = 32'h0100_0000;
    localparam logic [31:0] TH_2 = 32'h0200_0000;
    localparam logic [31:0] TH_3 = 32'h0300_0000;
    localparam logic [31:0] TH_4 = 32'h0400_0000;
    localparam logic [31:0] TH_6 = 32'h0600_0000;

    localparam logic [31:0] A_SEG0 = 32'h0000_0000;
    localparam logic [31:0] A_SEG1 = 32'h0180_0000;
    localparam logic [31:0] A_SEG2 = 32'h0280_0000;
    localparam logic [31:0] A_SEG3 = 32'h0380_0000;
    localparam logic [31:0] A_SEG4 = 32'h0500_0000;

    localparam logic [SEG_W-1:0] SEG_SAT = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEG    = 3'd1,
        ST_HORNER = 3'd2,
        ST_FIX    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic logic [SEG_W-1:0] seg_of(input logic [31:0] ax);
        if (ax < TH_1)      return 3'd0;
        else if (ax < TH_2) return 3'd1;
        else if (ax < TH_3) return 3'd2;
        else if (ax < TH_4) return 3'd3;
        else if (ax < TH_6) return 3'd4;
        else                return SEG_SAT;
    endfunction

    // The saturated segment reuses seg4's point; its d is never consumed.
    function automatic logic [31:0] exp_point(input logic [SEG_W-1:0] s);
        case (s)
            3'd1:    return A_SEG1;
            3'd2:    return A_SEG2;
            3'd3:    return A_SEG3;
            3'd4:    return A_SEG4;
            3'd5:    return A_SEG4;
            default: return A_SEG0;
        endcase
    endfunction

endpackage

// File: rtl/sig_coef_rom.sv
// Taylor coefficients C[s][k] = round(sigmoid^(k)(a_s)/k! * 2^24), Q8.24.
// Combinational lookup; the saturated segment has no polynomial.
module sig_coef_rom
    import sig_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [2:0]        seg,
    input  logic [1:0]        term,
    output logic [DWIDTH-1:0] coef
);

    always_comb begin
        coef = '0;
        case ({seg, term})
            5'b000_00: coef = DWIDTH'(HALF);
            5'b000_01: coef = DWIDTH'(32'sd4194304);
            5'b000_10: coef = '0;
            5'b000_11: coef = DWIDTH'(-32'sd349525);
            5'b001_00: coef = DWIDTH'(32'sd13716624);
            5'b001_01: coef = DWIDTH'(32'sd2502262);
            5'b001_10: coef = DWIDTH'(-32'sd794655);
            5'b001_11: coef = DWIDTH'(32'sd43840);
            5'b010_00: coef = DWIDTH'(32'sd15504527);
            5'b010_01: coef = DWIDTH'(32'sd1176145);
            5'b010_10: coef = DWIDTH'(-32'sd498852);
            5'b010_11: coef = DWIDTH'(32'sd113572);
            5'b011_00: coef = DWIDTH'(32'sd16285438);
            5'b011_01: coef = DWIDTH'(32'sd477363);
            5'b011_10: coef = DWIDTH'(-32'sd224689);
            5'b011_11: coef = DWIDTH'(32'sd65978);
            5'b100_00: coef = DWIDTH'(32'sd16664929);
            5'b100_01: coef = DWIDTH'(32'sd111536);
            5'b100_10: coef = DWIDTH'(-32'sd55021);
            5'b100_11: coef = DWIDTH'(32'sd17848);
            default:   coef = '0;
        endcase
    end

endmodule

// File: rtl/sigmoid_seq.sv
// Multi-cycle sigmoid(x) for one Q8.24 operand: segment select, Horner loop in
// (|x| - a) on one shared multiplier, then clamp and sign symmetry.
//   state  | meaning
//   IDLE   | ready; capture sign and |x| on in_valid
//   SEG    | pick segment, load d = |x| - a and top coefficient
//   HORNER | ORDER multiply-add steps, acc = trunc(acc*d) + C[seg][.]
//   FIX    | clamp to [0, ONE], mirror for negative x
//   DONE   | hold result until out_ready
module sigmoid_seq
    import sig_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int FRAC   = 24,
    parameter int ORDER  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              busy,
    output logic [2:0]        seg
);

    localparam logic [1:0]        TERM_TOP  = 2'(ORDER);
    localparam logic [1:0]        TERM_LAST = 2'(ORDER - 1);
    localparam logic [DWIDTH-1:0] ONE_W     = DWIDTH'(ONE);
    localparam logic [DWIDTH-1:0] MOST_NEG  = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic [DWIDTH-1:0] MOST_POS  = {1'b0, {(DWIDTH-1){1'b1}}};

    state_t            state_q, state_d;
    logic              neg_q, neg_d;
    logic [DWIDTH-1:0] ax_q, ax_d;
    logic [DWIDTH-1:0] d_q, d_d;
    logic [DWIDTH-1:0] acc_q, acc_d;
    logic [DWIDTH-1:0] out_data_q, out_data_d;
    logic [2:0]        seg_q, seg_d;
    logic [1:0]        k_q, k_d;

    logic [2:0]              seg_calc;
    logic [2:0]              rom_seg;
    logic [1:0]              rom_term;
    logic [DWIDTH-1:0]       rom_coef;
    logic signed [2*DWIDTH-1:0] prod;
    logic [DWIDTH-1:0]       prod_trunc;
    logic                    prod_unused;
    logic [DWIDTH-1:0]       p_clamp;

    assign seg_calc = seg_of(32'(ax_q));

    // One ROM port: SEG fetches the top term, HORNER walks down from there.
    assign rom_seg  = (state_q == ST_SEG) ? seg_calc : seg_q;
    assign rom_term = (state_q == ST_SEG) ? TERM_TOP : TERM_LAST - k_q;

    sig_coef_rom #(.DWIDTH(DWIDTH)) u_coef_rom (
        .seg  (rom_seg),
        .term (rom_term),
        .coef (rom_coef)
    );

    assign prod        = $signed(acc_q) * $signed(d_q);
    assign prod_trunc  = prod[DWIDTH+FRAC-1:FRAC];
    assign prod_unused = ^{prod[2*DWIDTH-1:DWIDTH+FRAC], prod[FRAC-1:0]};

    always_comb begin
        p_clamp = acc_q;
        if (seg_q == SEG_SAT)
            p_clamp = ONE_W;
        else if ($signed(acc_q) < 0)
            p_clamp = '0;
        else if ($signed(acc_q) > $signed(ONE_W))
            p_clamp = ONE_W;
    end

    always_comb begin
        state_d    = state_q;
        neg_d      = neg_q;
        ax_d       = ax_q;
        d_d        = d_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        seg_d      = seg_q;
        k_d        = k_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    neg_d = in_data[DWIDTH-1];
                    if (in_data == MOST_NEG)
                        ax_d = MOST_POS;
                    else if (in_data[DWIDTH-1])
                        ax_d = -in_data;
                    else
                        ax_d = in_data;
                    state_d = ST_SEG;
                end
            end
            ST_SEG: begin
                seg_d   = seg_calc;
                d_d     = ax_q - DWIDTH'(exp_point(seg_calc));
                acc_d   = rom_coef;
                k_d     = '0;
                state_d = (seg_calc == SEG_SAT) ? ST_FIX : ST_HORNER;
            end
            ST_HORNER: begin
                acc_d = prod_trunc + rom_coef;
                k_d   = k_q + 2'd1;
                if (k_q == TERM_LAST)
                    state_d = ST_FIX;
            end
            ST_FIX: begin
                out_data_d = neg_q ? (ONE_W - p_clamp) : p_clamp;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            neg_q      <= 1'b0;
            ax_q       <= '0;
            d_q        <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            seg_q      <= '0;
            k_q        <= '0;
        end else begin
            state_q    <= state_d;
            neg_q      <= neg_d;
            ax_q       <= ax_d;
            d_q        <= d_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            seg_q      <= seg_d;
            k_q        <= k_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_data_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_sigmoid_seq.sv
// Scoreboard bench for sigmoid_seq: directed operands push expected results,
// an independent monitor pops and compares whenever out_valid appears.
module tb_sigmoid_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic [2:0]  seg;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] expv;
        int          tol;
        logic [2:0]  sg;
        int          lat;
        int          t_acc;
        int          tag;
        string       name;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         mon_e;
    bit          seen = 1'b0;
    logic [31:0] res [0:31];

    sigmoid_seq #(.DWIDTH(32), .FRAC(24), .ORDER(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .seg       (seg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint act, input longint req, input longint tol);
        longint diff;
        diff = act - req;
        if (diff < 0) diff = -diff;
        checks++;
        if (diff > tol) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d tol=%0d", nm, act, req, tol);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid && !seen) begin
            seen = 1'b1;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%h required=none", out_data);
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.name, "_data"}, longint'($signed(out_data)), longint'($signed(mon_e.expv)), mon_e.tol);
                chk({mon_e.name, "_seg"}, seg, mon_e.sg, 0);
                chk({mon_e.name, "_lat"}, cyc - mon_e.t_acc, mon_e.lat, 0);
                res[mon_e.tag] = out_data;
            end
        end
        if (!out_valid) seen = 1'b0;
    end

    task automatic send(input logic [31:0] x, input logic [31:0] expv, input int tol,
                        input logic [2:0] sg, input int lat, input int tag,
                        input string nm, input bit push);
        int  n;
        sb_t e;
        @(negedge clk);
        in_data  = x;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_accept actual=not_ready required=ready", nm);
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            e.expv  = expv;
            e.tol   = tol;
            e.sg    = sg;
            e.lat   = lat;
            e.t_acc = cyc;
            e.tag   = tag;
            e.name  = nm;
            sb_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d_pending required=0", sb_q.size());
        end
    endtask

    task automatic mono(input int a, input int b);
        checks++;
        if (res[a] > res[b]) begin
            failures++;
            $display("FAIL monotonic_%0d_%0d actual=%h>%h required=nondecreasing", a, b, res[a], res[b]);
        end
    endtask

    initial begin
        int n;
        bit leaked;
        for (int i = 0; i < 32; i++) res[i] = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0, 0);
        chk("rst_out_valid", out_valid, 0, 0);
        chk("rst_out_data", out_data, 0, 0);
        chk("rst_busy", busy, 0, 0);
        chk("rst_seg", seg, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1, 0);

        send(32'h0000_0000, 32'd8388608,  0,     3'd0, 6, 0,  "zero",     1);
        send(32'h0080_0000, 32'd10442069, 2,     3'd0, 6, 1,  "p0_5",     1);
        send(32'h0180_0000, 32'd13716620, 4,     3'd1, 6, 2,  "p1_5",     1);
        send(32'hFE80_0000, 32'd3060596,  4,     3'd1, 6, 3,  "n1_5",     1);
        send(32'h0100_0000, 32'd12261349, 2,     3'd1, 6, 4,  "p1_0",     1);
        send(32'h00FF_FFFF, 32'd12265128, 65536, 3'd0, 6, 5,  "edge_lt1", 1);
        send(32'h0200_0000, 32'd14777545, 2,     3'd2, 6, 6,  "p2_0",     1);
        send(32'h0280_0000, 32'd15504527, 2,     3'd2, 6, 7,  "p2_5",     1);
        send(32'hFC80_0000, 32'd491778,   2,     3'd3, 6, 8,  "n3_5",     1);
        send(32'hFC00_0000, 32'd296692,   2,     3'd4, 6, 9,  "n4_0",     1);
        send(32'h0500_0000, 32'd16664929, 2,     3'd4, 6, 10, "p5_0",     1);
        send(32'h05FF_FFFF, 32'd16735732, 65536, 3'd4, 6, 11, "edge_lt6", 1);
        send(32'h0600_0000, 32'd16777216, 0,     3'd5, 3, 12, "p6_0",     1);
        send(32'h0700_0000, 32'd16777216, 0,     3'd5, 3, 13, "p7_0",     1);
        send(32'hF900_0000, 32'd0,        0,     3'd5, 3, 14, "n7_0",     1);
        send(32'h8000_0000, 32'd0,        0,     3'd5, 3, 15, "most_neg", 1);
        drain();

        mono(1, 5);
        mono(5, 4);
        mono(4, 2);
        mono(2, 6);
        mono(6, 7);
        mono(7, 10);
        mono(10, 11);
        mono(11, 12);

        // Backpressure: result must hold while out_ready is low.
        @(negedge clk);
        out_ready = 1'b0;
        send(32'h0000_0000, 32'd8388608, 0, 3'd0, 6, 16, "bp_zero", 1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", out_valid, 1, 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                in_data  = 32'h0700_0000;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            chk("bp_hold_valid", out_valid, 1, 0);
            chk("bp_hold_data", out_data, 32'd8388608, 0);
            chk("bp_in_ready", in_ready, 0, 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 1, 0);
        chk("bp_release_valid", out_valid, 0, 0);
        repeat (10) @(negedge clk);

        // Reset while in HORNER aborts the operand with no output.
        send(32'h0100_0000, 32'd0, 0, 3'd1, 6, 17, "abort", 0);
        @(negedge clk);
        chk("abort_busy_before", busy, 1, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 0, 0);
        chk("abort_out_valid", out_valid, 0, 0);
        chk("abort_out_data", out_data, 0, 0);
        chk("abort_busy", busy, 0, 0);
        chk("abort_seg", seg, 0, 0);
        rst = 1'b0;
        leaked = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) leaked = 1'b1;
        end
        chk("abort_no_output", leaked, 0, 0);
        send(32'h0000_0000, 32'd8388608, 0, 3'd0, 6, 18, "after_abort", 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
